// File: rtl/lsu_mem_port_pkg.sv
// Shared definitions for the load/store unit: opcodes, access widths, FSM states.
package lsu_mem_port_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_t;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, extraction/extension for loads, access legality.
module lsu_align
  import lsu_mem_port_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [1:0]  a,
  input  logic [31:0] store_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        bad,
  input  logic [2:0]  ld_func3,
  input  logic [1:0]  ld_a,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic        misal;
  logic [7:0]  lb;
  logic [15:0] lh;

  // Each lane picks the source byte it would carry for the access width.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    always_comb begin
      unique case (func3[1:0])
        2'b00:   wdata[8*i +: 8] = store_data[7:0];
        2'b01:   wdata[8*i +: 8] = store_data[8*(i%2) +: 8];
        default: wdata[8*i +: 8] = store_data[8*i +: 8];
      endcase
    end
  end

  always_comb begin
    unique case (func3[1:0])
      2'b00:   wstrb = 4'b0001 << a;
      2'b01:   wstrb = 4'b0011 << a;
      default: wstrb = 4'b1111;
    endcase
  end

  assign misal = ((func3[1:0] == 2'b01) && a[0]) || ((func3[1:0] == 2'b10) && (a != 2'b00));
  assign bad   = misal || !f3_legal(is_store, func3);

  assign lb = rdata[{ld_a, 3'b000} +: 8];
  assign lh = ld_a[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    unique case (ld_func3)
      F3_B:    ld_data = {{24{lb[7]}}, lb};
      F3_H:    ld_data = {{16{lh[15]}}, lh};
      F3_BU:   ld_data = {24'h0, lb};
      F3_HU:   ld_data = {16'h0, lh};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit: request/grant data-memory port with core stall and timeout.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [4:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state, nxt;
  logic        mem_op, is_store, bad, tmo, cap, at_limit;
  logic [2:0]  f3_q;
  logic [1:0]  a_q;
  logic [7:0]  cnt;
  logic [31:0] wdata_c, ld_c;
  logic [3:0]  wstrb_c;

  assign is_store = (opcode == OP_STORE);
  assign mem_op   = req_valid && ((opcode == OP_LOAD) || is_store);
  assign at_limit = (cnt == 8'(MAX_WAIT - 1));

  lsu_align u_align (
    .is_store   (is_store),
    .func3      (func3),
    .a          (addr[1:0]),
    .store_data (store_data),
    .wdata      (wdata_c),
    .wstrb      (wstrb_c),
    .bad        (bad),
    .ld_func3   (f3_q),
    .ld_a       (a_q),
    .rdata      (mem_rdata),
    .ld_data    (ld_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    tmo = 1'b0;
    cap = 1'b0;
    unique case (state)
      S_IDLE: if (mem_op) nxt = bad ? S_DONE : S_REQ;
      S_REQ: begin
        if (mem_gnt) begin
          if (mem_we)          nxt = S_DONE;
          else if (mem_rvalid) begin nxt = S_DONE; cap = 1'b1; end
          else                 nxt = S_WAIT;
        end else if (at_limit) begin
          nxt = S_DONE; tmo = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rvalid)    begin nxt = S_DONE; cap = 1'b1; end
        else if (at_limit) begin nxt = S_DONE; tmo = 1'b1; end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req    = (state == S_REQ);
    resp_valid = (state == S_DONE);
    stall      = (state == S_REQ) || (state == S_WAIT) || ((state == S_IDLE) && mem_op);
  end

  // Bus fields are latched at accept so they stay stable through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q      <= '0;
      a_q       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      load_data <= '0;
    end else begin
      if (state == S_IDLE && mem_op) begin
        f3_q      <= func3;
        a_q       <= addr[1:0];
        mem_we    <= is_store;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wstrb <= wstrb_c;
        mem_wdata <= wdata_c;
        err       <= bad;
      end
      if (tmo) err       <= 1'b1;
      if (cap) load_data <= ld_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if ((state == S_REQ || state == S_WAIT) && nxt != S_DONE) cnt <= cnt + 8'd1;
    else cnt <= '0;
  end

endmodule
